// File: rtl/keypad_scanner.sv
// Purpose: 4x4 active-low matrix keypad scanner with 2-flop column synchroniser and press/release debounce.
// Latency: key_valid pulses 1 clk after the DEBOUNCE_CNT-th matching sample; samples are SCAN_DIV clk apart.
// Backpressure: none; free-running scan, the press event is a single-cycle pulse that is never held off.
module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] keypadCol,
    output logic [3:0] keypadRow,
    output logic       key_valid,
    output logic [1:0] key_row,
    output logic [1:0] key_col,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CNT + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    // Counter value that, once one more matching sample arrives, completes the debounce
    localparam logic [CW-1:0] CNT_TOP    = CW'(DEBOUNCE_CNT - 1);

    typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, HELD} state_t;

    state_t        state;
    logic [3:0]    col_meta;
    logic [3:0]    col_s;
    logic [DW-1:0] dwell;
    logic [1:0]    row;
    logic [1:0]    cap_col;
    logic [CW-1:0] deb;
    logic [CW-1:0] rel;
    logic          sample_pt;
    logic          col_single;
    logic [1:0]    col_idx;

    // Active-low drive pattern for a given row
    function automatic logic [3:0] row_drive(input logic [1:0] r);
        return ~(4'b0001 << r);
    endfunction

    // Two-flop synchroniser for the asynchronous column inputs; idles at "no key"
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= 4'b1111;
            col_s    <= 4'b1111;
        end else begin
            col_meta <= keypadCol;
            col_s    <= col_meta;
        end
    end

    assign sample_pt = (dwell == DWELL_LAST);

    // Decode exactly one pressed column; multiple zeros are treated as no key
    always_comb begin
        col_single = 1'b0;
        col_idx    = 2'd0;
        case (col_s)
            4'b1110: begin col_single = 1'b1; col_idx = 2'd0; end
            4'b1101: begin col_single = 1'b1; col_idx = 2'd1; end
            4'b1011: begin col_single = 1'b1; col_idx = 2'd2; end
            4'b0111: begin col_single = 1'b1; col_idx = 2'd3; end
            default: begin col_single = 1'b0; col_idx = 2'd0; end
        endcase
    end

    // Scan / debounce / held FSM with all outputs registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            keypadRow <= 4'b1111;
            key_valid <= 1'b0;
            key_row   <= 2'd0;
            key_col   <= 2'd0;
            key_held  <= 1'b0;
            dwell     <= '0;
            row       <= 2'd0;
            cap_col   <= 2'd0;
            deb       <= '0;
            rel       <= '0;
        end else if (!enable) begin
            // Leaving the game drops any pending press; last key identity is kept
            state     <= IDLE;
            keypadRow <= 4'b1111;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
            dwell     <= '0;
            row       <= 2'd0;
            deb       <= '0;
            rel       <= '0;
        end else begin
            key_valid <= 1'b0;
            if (state == IDLE) begin
                state     <= SCAN;
                row       <= 2'd0;
                dwell     <= '0;
                keypadRow <= row_drive(2'd0);
            end else begin
                dwell <= sample_pt ? '0 : dwell + DW'(1);
                case (state)
                    SCAN: begin
                        if (sample_pt) begin
                            if (col_single) begin
                                cap_col <= col_idx;
                                if (DEBOUNCE_CNT == 1) begin
                                    key_valid <= 1'b1;
                                    key_row   <= row;
                                    key_col   <= col_idx;
                                    key_held  <= 1'b1;
                                    rel       <= '0;
                                    state     <= HELD;
                                end else begin
                                    deb   <= CW'(1);
                                    state <= DEBOUNCE;
                                end
                            end else begin
                                row       <= row + 2'd1;
                                keypadRow <= row_drive(row + 2'd1);
                            end
                        end
                    end
                    DEBOUNCE: begin
                        if (sample_pt) begin
                            if (col_single && (col_idx == cap_col)) begin
                                if (deb == CNT_TOP) begin
                                    key_valid <= 1'b1;
                                    key_row   <= row;
                                    key_col   <= cap_col;
                                    key_held  <= 1'b1;
                                    deb       <= '0;
                                    rel       <= '0;
                                    state     <= HELD;
                                end else begin
                                    deb <= deb + CW'(1);
                                end
                            end else begin
                                // Bounce: resume scanning after the row that glitched
                                deb       <= '0;
                                row       <= row + 2'd1;
                                keypadRow <= row_drive(row + 2'd1);
                                state     <= SCAN;
                            end
                        end
                    end
                    HELD: begin
                        if (sample_pt) begin
                            if (col_s[cap_col]) begin
                                if (rel == CNT_TOP) begin
                                    rel       <= '0;
                                    key_held  <= 1'b0;
                                    row       <= 2'd0;
                                    keypadRow <= row_drive(2'd0);
                                    state     <= SCAN;
                                end else begin
                                    rel <= rel + CW'(1);
                                end
                            end else begin
                                rel <= '0;
                            end
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        keypadRow <= 4'b1111;
                    end
                endcase
            end
        end
    end

endmodule
